// File: rtl/timer_pkg.sv
// Shared definitions for the bus-attached machine timer.
//   - Register offsets as seen on dev_addr_i[4:2]
//   - Reset value of MTIMECMP
//   - CTRL bit positions, plus a helper that assembles the CTRL read-back word
// Optional feature macro: TIMER_PRESCALE_EN (see bus_timer_device.sv).
package timer_pkg;

    localparam logic [2:0] OFF_MTIME_LO    = 3'd0;
    localparam logic [2:0] OFF_MTIME_HI    = 3'd1;
    localparam logic [2:0] OFF_MTIMECMP_LO = 3'd2;
    localparam logic [2:0] OFF_MTIMECMP_HI = 3'd3;
    localparam logic [2:0] OFF_CTRL        = 3'd4;
    localparam logic [2:0] OFF_STATUS      = 3'd5;

    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_PSC_LSB = 8;
    localparam int CTRL_PSC_MSB = 15;

    // CTRL read-back: enable in bit 0, prescale value in [15:8], all else zero.
    function automatic logic [31:0] ctrl_word(input logic en, input logic [7:0] psc);
        logic [31:0] w;
        w = 32'd0;
        w[CTRL_EN_BIT] = en;
        w[CTRL_PSC_MSB:CTRL_PSC_LSB] = psc;
        return w;
    endfunction

endpackage

// File: rtl/bus_timer_device_if.sv
// Single-cycle host/device bus, device slot.
//   dev_req_i    request qualifier (one cycle)
//   dev_we_i     1 = write, 0 = read
//   dev_addr_i   byte address
//   dev_wdata_i  write data (full word)
//   dev_rdata_o  read data, cycle after a read request
//   dev_rvalid_o response strobe, cycle after any request
// Signal names carry the direction as seen from the device.
interface bus_timer_device_if #(
    parameter int DW = 32,
    parameter int AW = 32
) ();
    logic          dev_req_i;
    logic          dev_we_i;
    logic [AW-1:0] dev_addr_i;
    logic [DW-1:0] dev_wdata_i;
    logic [DW-1:0] dev_rdata_o;
    logic          dev_rvalid_o;

    modport master (
        output dev_req_i, dev_we_i, dev_addr_i, dev_wdata_i,
        input  dev_rdata_o, dev_rvalid_o
    );

    modport slave (
        input  dev_req_i, dev_we_i, dev_addr_i, dev_wdata_i,
        output dev_rdata_o, dev_rvalid_o
    );
endinterface

// File: rtl/timer_prescaler.sv
// Tick generator for the machine timer: one tick every (i_prescale + 1) cycles.
//   clk_i, rst_i  clock, asynchronous active-high reset
//   i_enable      timer enable (CTRL[0]); counter held at zero while low
//   i_clear       CTRL write strobe; restarts the count
//   i_prescale    divider value P
//   o_tick        single-cycle tick strobe
module timer_prescaler (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       i_enable,
    input  logic       i_clear,
    input  logic [7:0] i_prescale,
    output logic       o_tick
);
    logic [7:0] r_cnt;
    logic       w_wrap;

    assign w_wrap = (r_cnt == i_prescale);
    // No tick on the CTRL-write cycle: the count restarts from the new setting.
    assign o_tick = i_enable && !i_clear && w_wrap;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= 8'd0;
        end else if (i_clear || !i_enable || w_wrap) begin
            r_cnt <= 8'd0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end
endmodule

// File: rtl/bus_timer_device.sv
// Bus-side responder implementing a 64-bit machine timer (mtime / mtimecmp)
// with a registered level interrupt.
//   clk_i, rst_i  clock, asynchronous active-high reset
//   bus           device end of the single-cycle bus (bus_timer_device_if.slave)
//   timer_irq_o   level interrupt, registered: mtime >= mtimecmp
// Register map on dev_addr_i[4:2]: 0 MTIME_LO, 1 MTIME_HI, 2 MTIMECMP_LO,
// 3 MTIMECMP_HI, 4 CTRL, 5 STATUS (RO), 6/7 unmapped (read 0, writes ignored).
// Optional macro TIMER_PRESCALE_EN: CTRL[15:8] becomes a tick divider;
// without it the timer ticks every cycle while enabled and CTRL[15:8] reads 0.
module bus_timer_device
    import timer_pkg::*;
#(
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    bus_timer_device_if.slave  bus,
    output logic               timer_irq_o
);
    if (DataWidth != 32) begin : g_bad_width
        $error("bus_timer_device: only DataWidth=32 is supported");
    end

    logic [63:0]          r_mtime;
    logic [63:0]          r_mtimecmp;
    logic                 r_ctrl_en;
    logic [31:0]          r_hi_shadow;
    logic [DataWidth-1:0] r_rdata;
    logic                 r_rvalid;
    logic                 r_irq;

    logic                 w_wr;
    logic                 w_rd;
    logic [2:0]           w_off;
    logic                 w_ctrl_wr;
    logic                 w_tick;
    logic [7:0]           w_psc;
    logic [31:0]          w_rd_mux;
    logic                 w_unused_addr;

    assign w_wr      = bus.dev_req_i && bus.dev_we_i;
    assign w_rd      = bus.dev_req_i && !bus.dev_we_i;
    assign w_off     = bus.dev_addr_i[4:2];
    assign w_ctrl_wr = w_wr && (w_off == OFF_CTRL);

    // Upper address bits are decoded by the interconnect; byte offset is ignored.
    assign w_unused_addr = ^{bus.dev_addr_i[AddressWidth-1:5], bus.dev_addr_i[1:0]};

`ifdef TIMER_PRESCALE_EN
    logic [7:0] r_psc;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_psc <= 8'd0;
        end else if (w_ctrl_wr) begin
            r_psc <= bus.dev_wdata_i[CTRL_PSC_MSB:CTRL_PSC_LSB];
        end
    end

    assign w_psc = r_psc;

    timer_prescaler u_prescaler (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .i_enable   (r_ctrl_en),
        .i_clear    (w_ctrl_wr),
        .i_prescale (r_psc),
        .o_tick     (w_tick)
    );
`else
    assign w_psc  = 8'd0;
    assign w_tick = r_ctrl_en;
`endif

    // Read mux works on pre-update register values.
    always_comb begin
        w_rd_mux = 32'd0;
        case (w_off)
            OFF_MTIME_LO:    w_rd_mux = r_mtime[31:0];
            OFF_MTIME_HI:    w_rd_mux = r_hi_shadow;
            OFF_MTIMECMP_LO: w_rd_mux = r_mtimecmp[31:0];
            OFF_MTIMECMP_HI: w_rd_mux = r_mtimecmp[63:32];
            OFF_CTRL:        w_rd_mux = ctrl_word(r_ctrl_en, w_psc);
            OFF_STATUS:      w_rd_mux = {31'd0, r_irq};
            default:         w_rd_mux = 32'd0;
        endcase
    end

    // mtime: a bus write to either half wins over the tick in that cycle,
    // so the increment (and any carry) is simply dropped.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mtime <= 64'd0;
        end else if (w_wr && (w_off == OFF_MTIME_LO)) begin
            r_mtime[31:0] <= bus.dev_wdata_i;
        end else if (w_wr && (w_off == OFF_MTIME_HI)) begin
            r_mtime[63:32] <= bus.dev_wdata_i;
        end else if (w_tick) begin
            r_mtime <= r_mtime + 64'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mtimecmp <= MTIMECMP_RST;
            r_ctrl_en  <= 1'b0;
        end else if (w_wr) begin
            case (w_off)
                OFF_MTIMECMP_LO: r_mtimecmp[31:0]  <= bus.dev_wdata_i;
                OFF_MTIMECMP_HI: r_mtimecmp[63:32] <= bus.dev_wdata_i;
                OFF_CTRL:        r_ctrl_en         <= bus.dev_wdata_i[CTRL_EN_BIT];
                default:         ;
            endcase
        end
    end

    // Reading MTIME_LO snapshots the upper half so a LO-then-HI pair is coherent.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_hi_shadow <= 32'd0;
        end else if (w_rd && (w_off == OFF_MTIME_LO)) begin
            r_hi_shadow <= r_mtime[63:32];
        end
    end

    // Response and interrupt registers; writes return zero data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_irq    <= 1'b0;
        end else begin
            r_rvalid <= bus.dev_req_i;
            r_rdata  <= w_rd ? w_rd_mux : '0;
            r_irq    <= (r_mtime >= r_mtimecmp);
        end
    end

    assign bus.dev_rdata_o  = r_rdata;
    assign bus.dev_rvalid_o = r_rvalid;
    assign timer_irq_o      = r_irq;
endmodule

// File: tb/tb_bus_timer_device.sv
// Directed bench for bus_timer_device: reset state, counting, write-wins,
// atomic LO/HI read, 64-bit wrap, interrupt rise/fall, unmapped/RO offsets,
// CTRL read-back, optional prescaler and asynchronous reset.
module tb_bus_timer_device;
    logic clk;
    logic rst;
    logic irq;
    int   n_checks;
    int   n_fail;
    logic [31:0] rd;

    bus_timer_device_if #(.DW(32), .AW(32)) u_bus ();

    bus_timer_device #(.DataWidth(32), .AddressWidth(32)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus         (u_bus),
        .timer_irq_o (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] off, input logic [31:0] d);
        @(negedge clk);
        u_bus.dev_req_i   = 1'b1;
        u_bus.dev_we_i    = 1'b1;
        u_bus.dev_addr_i  = {27'd0, off, 2'b00};
        u_bus.dev_wdata_i = d;
        @(posedge clk);
        #1;
        u_bus.dev_req_i   = 1'b0;
        u_bus.dev_we_i    = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] off, output logic [31:0] d);
        @(negedge clk);
        u_bus.dev_req_i   = 1'b1;
        u_bus.dev_we_i    = 1'b0;
        u_bus.dev_addr_i  = {27'd0, off, 2'b00};
        u_bus.dev_wdata_i = 32'd0;
        @(posedge clk);
        #1;
        u_bus.dev_req_i   = 1'b0;
        d = u_bus.dev_rdata_o;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        u_bus.dev_req_i   = 1'b0;
        u_bus.dev_we_i    = 1'b0;
        u_bus.dev_addr_i  = 32'd0;
        u_bus.dev_wdata_i = 32'd0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rvalid", {31'd0, u_bus.dev_rvalid_o}, 32'd0);
        chk("rst_rdata", u_bus.dev_rdata_o, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Reset value of MTIMECMP
        bus_read(3'd2, rd);
        chk("rst_cmp_lo", rd, 32'hFFFF_FFFF);
        chk("rst_cmp_rvalid", {31'd0, u_bus.dev_rvalid_o}, 32'd1);
        chk("rst_cmp_irq", {31'd0, irq}, 32'd0);

        // Free-running count: enable, 10 cycles, read
        bus_write(3'd4, 32'd1);
        chk("wr_rvalid", {31'd0, u_bus.dev_rvalid_o}, 32'd1);
        chk("wr_rdata", u_bus.dev_rdata_o, 32'd0);
        repeat (10) @(posedge clk);
        bus_read(3'd0, rd);
        n_checks++;
        assert (rd >= 32'd9 && rd <= 32'd11) else begin
            n_fail++;
            $error("FAIL count10 observed=%0d expected=10+/-1", rd);
        end
        @(posedge clk);
        #1;
        chk("rvalid_one_cycle", {31'd0, u_bus.dev_rvalid_o}, 32'd0);

        // Write wins over same-cycle tick
        bus_write(3'd0, 32'd100);
        bus_read(3'd0, rd);
        chk("write_wins", rd, 32'd100);

        // Carry into HI and shadowed HI read
        bus_write(3'd4, 32'd0);
        bus_write(3'd1, 32'd0);
        bus_write(3'd0, 32'hFFFF_FFFE);
        bus_write(3'd4, 32'd1);
        repeat (3) @(posedge clk);
        bus_read(3'd0, rd);
        chk("carry_lo", rd, 32'd1);
        bus_write(3'd1, 32'd5);
        bus_read(3'd1, rd);
        chk("shadow_hi", rd, 32'd1);
        bus_read(3'd0, rd);
        bus_read(3'd1, rd);
        chk("shadow_hi_new", rd, 32'd5);

        // 64-bit wrap
        bus_write(3'd4, 32'd0);
        bus_write(3'd1, 32'hFFFF_FFFF);
        bus_write(3'd0, 32'hFFFF_FFFF);
        bus_write(3'd4, 32'd1);
        @(posedge clk);
        bus_read(3'd0, rd);
        chk("wrap_lo", rd, 32'd0);
        bus_read(3'd1, rd);
        chk("wrap_hi", rd, 32'd0);

        // Interrupt rise at mtime == 20, fall after raising mtimecmp
        bus_write(3'd4, 32'd0);
        bus_write(3'd1, 32'd0);
        bus_write(3'd0, 32'd0);
        bus_write(3'd3, 32'd0);
        bus_write(3'd2, 32'd20);
        @(posedge clk);
        #1;
        chk("irq_idle", {31'd0, irq}, 32'd0);
        bus_write(3'd4, 32'd1);
        repeat (20) @(posedge clk);
        #1;
        chk("irq_before", {31'd0, irq}, 32'd0);
        @(posedge clk);
        #1;
        chk("irq_rise", {31'd0, irq}, 32'd1);
        bus_read(3'd5, rd);
        chk("status_set", rd, 32'd1);
        bus_write(3'd2, 32'd1000);
        chk("irq_hold", {31'd0, irq}, 32'd1);
        @(posedge clk);
        #1;
        chk("irq_fall", {31'd0, irq}, 32'd0);

        // Unmapped and read-only offsets
        bus_read(3'd7, rd);
        chk("unmapped_rdata", rd, 32'd0);
        chk("unmapped_rvalid", {31'd0, u_bus.dev_rvalid_o}, 32'd1);
        bus_write(3'd6, 32'hDEAD_BEEF);
        bus_read(3'd6, rd);
        chk("unmapped6_rdata", rd, 32'd0);
        bus_write(3'd2, 32'd0);
        @(posedge clk);
        bus_write(3'd5, 32'd0);
        bus_read(3'd5, rd);
        chk("status_ro", rd, 32'd1);

        // CTRL read-back
        bus_write(3'd4, 32'h0000_0301);
        bus_read(3'd4, rd);
`ifdef TIMER_PRESCALE_EN
        chk("ctrl_readback", rd, 32'h0000_0301);
`else
        chk("ctrl_readback", rd, 32'h0000_0001);
`endif

`ifdef TIMER_PRESCALE_EN
        // One tick every 4 cycles
        bus_write(3'd4, 32'd0);
        bus_write(3'd1, 32'd0);
        bus_write(3'd0, 32'd0);
        bus_write(3'd4, 32'h0000_0301);
        repeat (7) @(posedge clk);
        bus_read(3'd0, rd);
        chk("psc_first", rd, 32'd1);
        repeat (3) @(posedge clk);
        bus_read(3'd0, rd);
        chk("psc_second", rd, 32'd2);
`endif

        // Asynchronous reset in the middle of a response; irq is high (mtimecmp=0)
        bus_read(3'd5, rd);
        chk("pre_rst_rvalid", {31'd0, u_bus.dev_rvalid_o}, 32'd1);
        chk("pre_rst_irq", {31'd0, irq}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_rvalid", {31'd0, u_bus.dev_rvalid_o}, 32'd0);
        chk("async_rst_rdata", u_bus.dev_rdata_o, 32'd0);
        chk("async_rst_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus_read(3'd0, rd);
        chk("post_rst_mtime", rd, 32'd0);
        bus_read(3'd3, rd);
        chk("post_rst_cmp_hi", rd, 32'hFFFF_FFFF);
        bus_read(3'd4, rd);
        chk("post_rst_ctrl", rd, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
